// File: rtl/mips_instr_encoder.sv
// Packs field-level MIPS instruction requests into 32-bit words and streams them
// into instruction memory at consecutive word addresses through a write/ack handshake.
module mips_instr_encoder #(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [2:0]            i_req_kind,
    input  logic                  i_req_last,
    input  logic [4:0]            i_req_rs,
    input  logic [4:0]            i_req_rt,
    input  logic [4:0]            i_req_rd,
    input  logic [4:0]            i_req_shamt,
    input  logic [5:0]            i_req_funct,
    input  logic [15:0]           i_req_imm,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    input  logic                  i_imem_ack,
    output logic                  o_done,
    output logic                  o_full,
    output logic                  o_err_illegal,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST     = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Field packing for the opcode subset the core decodes; unused fields are dropped.
    function automatic logic [31:0] f_encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (kind)
            3'd0:    word = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    word = {6'b100011, rs, rt, imm};
            3'd2:    word = {6'b101011, rs, rt, imm};
            3'd3:    word = {6'b000100, rs, rt, imm};
            3'd4:    word = {6'b001000, rs, rt, imm};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    function automatic logic f_kind_legal(input logic [2:0] kind);
        return (kind <= 3'd4);
    endfunction

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_ready;
    logic                    r_we;
    logic                    r_done;
    logic                    r_full;
    logic                    r_err;
    logic                    r_last;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    w_legal;
    logic                    w_at_last_addr;

    assign w_legal        = f_kind_legal(i_req_kind);
    assign w_at_last_addr = (r_addr == LP_LAST);

    // Next-state logic for the session sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_next_state = S_ACCEPT;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_ACCEPT: begin
                if (i_req_valid) begin
                    if (w_legal) begin
                        w_next_state = S_WRITE;
                    end else if (i_req_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_ACCEPT;
                    end
                end else begin
                    w_next_state = S_ACCEPT;
                end
            end
            S_WRITE: begin
                if (i_imem_ack) begin
                    if (w_at_last_addr || r_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_ACCEPT;
                    end
                end else begin
                    w_next_state = S_WRITE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register with output flags registered from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == S_ACCEPT);
            r_we    <= (w_next_state == S_WRITE);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // Address pointer, encoded word, counters and sticky session flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr  <= LP_BASE;
            r_wdata <= 32'h0000_0000;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_addr  <= LP_BASE;
                        r_count <= '0;
                        r_full  <= 1'b0;
                        r_err   <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (i_req_valid) begin
                        if (w_legal) begin
                            r_wdata <= f_encode(i_req_kind, i_req_rs, i_req_rt, i_req_rd,
                                                i_req_shamt, i_req_funct, i_req_imm);
                            r_last  <= i_req_last;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_imem_ack) begin
                        r_count <= r_count + LP_CNT_ONE;
                        // The top word is never wrapped past; the session ends full instead.
                        if (w_at_last_addr) begin
                            r_full <= 1'b1;
                        end else if (!r_last) begin
                            r_addr <= r_addr + LP_ADDR_ONE;
                        end
                    end
                end
                default: begin
                    r_last <= r_last;
                end
            endcase
        end
    end

    assign o_req_ready   = r_ready;
    assign o_imem_we     = r_we;
    assign o_imem_addr   = r_addr;
    assign o_imem_wdata  = r_wdata;
    assign o_done        = r_done;
    assign o_full        = r_full;
    assign o_err_illegal = r_err;
    assign o_word_count  = r_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: default geometry instance plus a tiny
// 4-word instance used to exercise the end-of-memory stop.
module tb_mips_instr_encoder;

    logic        clk;
    logic        rst;

    logic        a_start, a_valid, a_last, a_ack;
    logic [2:0]  a_kind;
    logic [4:0]  a_rs, a_rt, a_rd, a_shamt;
    logic [5:0]  a_funct;
    logic [15:0] a_imm;
    logic        a_ready, a_we, a_done, a_full, a_err;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic [6:0]  a_count;

    logic        b_start, b_valid;
    logic        b_ready, b_we, b_done, b_full, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    int n_cmp;
    int n_err;

    mips_instr_encoder #(.ADDR_WIDTH(6), .BASE_ADDR(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_req_valid(a_valid),
        .o_req_ready(a_ready), .i_req_kind(a_kind), .i_req_last(a_last),
        .i_req_rs(a_rs), .i_req_rt(a_rt), .i_req_rd(a_rd), .i_req_shamt(a_shamt),
        .i_req_funct(a_funct), .i_req_imm(a_imm), .o_imem_we(a_we),
        .o_imem_addr(a_addr), .o_imem_wdata(a_wdata), .i_imem_ack(a_ack),
        .o_done(a_done), .o_full(a_full), .o_err_illegal(a_err), .o_word_count(a_count)
    );

    mips_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_req_valid(b_valid),
        .o_req_ready(b_ready), .i_req_kind(3'd4), .i_req_last(1'b0),
        .i_req_rs(5'd0), .i_req_rt(5'd1), .i_req_rd(5'd0), .i_req_shamt(5'd0),
        .i_req_funct(6'd0), .i_req_imm(16'h0001), .o_imem_we(b_we),
        .o_imem_addr(b_addr), .o_imem_wdata(b_wdata), .i_imem_ack(1'b1),
        .o_done(b_done), .o_full(b_full), .o_err_illegal(b_err), .o_word_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_set(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic last);
        a_kind = kind; a_rs = rs; a_rt = rt; a_rd = rd;
        a_shamt = sh; a_funct = fn; a_imm = imm; a_last = last;
    endtask

    task automatic a_start_pulse();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    // Present the request, wait (bounded) for ready, complete the handshake edge.
    task automatic a_handshake(input string tag);
        int n;
        n = 0;
        a_valid = 1'b1;
        while (!a_ready && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_ready"}, {31'd0, a_ready}, 32'd1);
        step();
        a_valid = 1'b0;
    endtask

    task automatic a_write(input string tag, input logic [5:0] exp_addr,
                           input logic [31:0] exp_data, input logic [6:0] exp_cnt);
        a_handshake(tag);
        check_eq({tag, "_we"},   {31'd0, a_we}, 32'd1);
        check_eq({tag, "_addr"}, {26'd0, a_addr}, {26'd0, exp_addr});
        check_eq({tag, "_data"}, a_wdata, exp_data);
        step();
        check_eq({tag, "_cnt"},  {25'd0, a_count}, {25'd0, exp_cnt});
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_ack = 1'b1;
        b_start = 1'b0; b_valid = 1'b0;
        a_set(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_ready", {31'd0, a_ready}, 32'd0);
        check_eq("rst_we",    {31'd0, a_we}, 32'd0);
        check_eq("rst_addr",  {26'd0, a_addr}, 32'd0);
        check_eq("rst_wdata", a_wdata, 32'd0);
        check_eq("rst_flags", {28'd0, a_done, a_full, a_err, 1'b0}, 32'd0);
        check_eq("rst_cnt",   {25'd0, a_count}, 32'd0);
        check_eq("rst_b_addr", {30'd0, b_addr}, 32'd2);
        step(); step();
        rst = 1'b0;
        step();

        // Basic session: one of each kind, beq last.
        a_start_pulse();
        check_eq("start_ready", {31'd0, a_ready}, 32'd1);
        a_set(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b0);
        a_write("addi", 6'd0, 32'h2008_0005, 7'd1);
        check_eq("addi_ready_back", {31'd0, a_ready}, 32'd1);
        a_set(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'hABCD, 1'b0);
        a_write("rtype", 6'd1, 32'h0109_5020, 7'd2);
        a_set(3'd1, 5'd8, 5'd9, 5'd31, 5'd3, 6'h3F, 16'h0004, 1'b0);
        a_write("lw", 6'd2, 32'h8D09_0004, 7'd3);
        a_set(3'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0008, 1'b0);
        a_write("sw", 6'd3, 32'hAD09_0008, 7'd4);
        a_set(3'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1);
        a_write("beq", 6'd4, 32'h1109_FFFF, 7'd5);
        check_eq("s1_done",  {31'd0, a_done}, 32'd1);
        check_eq("s1_full",  {31'd0, a_full}, 32'd0);
        check_eq("s1_ready", {31'd0, a_ready}, 32'd0);
        step();
        check_eq("s1_idle_we", {31'd0, a_we}, 32'd0);

        // Ack stall: outputs hold, count waits for the ack cycle.
        a_start_pulse();
        check_eq("s2_cnt_clr", {25'd0, a_count}, 32'd0);
        check_eq("s2_done_clr", {31'd0, a_done}, 32'd0);
        a_ack = 1'b0;
        a_set(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b0);
        a_handshake("stall");
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_we",    {31'd0, a_we}, 32'd1);
            check_eq("stall_addr",  {26'd0, a_addr}, 32'd0);
            check_eq("stall_data",  a_wdata, 32'h2022_1234);
            check_eq("stall_ready", {31'd0, a_ready}, 32'd0);
            check_eq("stall_cnt",   {25'd0, a_count}, 32'd0);
            step();
        end
        a_ack = 1'b1;
        step();
        check_eq("stall_cnt_ack", {25'd0, a_count}, 32'd1);
        check_eq("stall_ready_back", {31'd0, a_ready}, 32'd1);

        // Illegal kind consumed without a write; next word stays sequential.
        a_set(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 1'b0);
        a_handshake("illegal");
        check_eq("ill_we",    {31'd0, a_we}, 32'd0);
        check_eq("ill_err",   {31'd0, a_err}, 32'd1);
        check_eq("ill_cnt",   {25'd0, a_count}, 32'd1);
        check_eq("ill_ready", {31'd0, a_ready}, 32'd1);
        a_set(3'd4, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0007, 1'b1);
        a_write("after_ill", 6'd1, 32'h2003_0007, 7'd2);
        check_eq("ill_done",   {31'd0, a_done}, 32'd1);
        check_eq("ill_sticky", {31'd0, a_err}, 32'd1);
        a_start_pulse();
        check_eq("ill_err_clr", {31'd0, a_err}, 32'd0);

        // Small memory: two writes at 2 and 3, then full; third request refused.
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_valid = 1'b1;
        check_eq("b_ready", {31'd0, b_ready}, 32'd1);
        step();
        check_eq("b_w1_we",   {31'd0, b_we}, 32'd1);
        check_eq("b_w1_addr", {30'd0, b_addr}, 32'd2);
        check_eq("b_w1_data", b_wdata, 32'h2001_0001);
        step();
        step();
        check_eq("b_w2_we",   {31'd0, b_we}, 32'd1);
        check_eq("b_w2_addr", {30'd0, b_addr}, 32'd3);
        step();
        check_eq("b_full",  {31'd0, b_full}, 32'd1);
        check_eq("b_done",  {31'd0, b_done}, 32'd1);
        check_eq("b_cnt",   {29'd0, b_count}, 32'd2);
        step();
        step();
        check_eq("b_no_3rd_we",  {31'd0, b_we}, 32'd0);
        check_eq("b_no_3rd_cnt", {29'd0, b_count}, 32'd2);
        check_eq("b_no_3rd_rdy", {31'd0, b_ready}, 32'd0);
        b_valid = 1'b0;

        // Reset in the middle of a stalled write (session already flagged illegal).
        a_set(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
        a_handshake("pre_rst_ill");
        a_ack = 1'b0;
        a_set(3'd1, 5'd2, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b0);
        a_handshake("pre_rst");
        check_eq("pre_rst_we", {31'd0, a_we}, 32'd1);
        check_eq("pre_rst_err", {31'd0, a_err}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_we",    {31'd0, a_we}, 32'd0);
        check_eq("mid_rst_addr",  {26'd0, a_addr}, 32'd0);
        check_eq("mid_rst_wdata", a_wdata, 32'd0);
        check_eq("mid_rst_err",   {31'd0, a_err}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, a_ready}, 32'd0);
        check_eq("mid_rst_b_full", {31'd0, b_full}, 32'd0);
        step(); step();
        rst = 1'b0;
        a_ack = 1'b1;
        step();
        a_start_pulse();
        a_set(3'd2, 5'd3, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0020, 1'b1);
        a_write("post_rst", 6'd0, 32'hAC65_0020, 7'd1);
        check_eq("post_rst_done", {31'd0, a_done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
